// File: rtl/prog_load_controller_if.sv
`default_nettype none
// prog_load_controller_if: bus bundle linking the boot/debug sequencer to UART RX/TX,
// instruction/data memories and the pipeline control inputs. Rev 1.0
interface prog_load_controller_if #(
  parameter int IMEM_ADDR_W = 8,
  parameter int DMEM_ADDR_W = 8
);
  logic                   Enable_Instruction_Input;
  logic                   start;
  logic                   Enable_Data_Output;
  logic                   rx_valid;
  logic [7:0]             rx_byte;
  logic                   imem_we;
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [31:0]            imem_wdata;
  logic                   cpu_rst;
  logic                   cpu_run;
  logic [DMEM_ADDR_W-1:0] dmem_raddr;
  logic [31:0]            dmem_rdata;
  logic                   tx_start;
  logic [7:0]             tx_byte;
  logic                   tx_busy;
  logic [IMEM_ADDR_W:0]   load_count;
  logic                   overflow;
  logic                   dump_done;

  modport master (
    input  Enable_Instruction_Input, start, Enable_Data_Output, rx_valid, rx_byte,
           dmem_rdata, tx_busy,
    output imem_we, imem_addr, imem_wdata, cpu_rst, cpu_run, dmem_raddr,
           tx_start, tx_byte, load_count, overflow, dump_done
  );

  modport slave (
    output Enable_Instruction_Input, start, Enable_Data_Output, rx_valid, rx_byte,
           dmem_rdata, tx_busy,
    input  imem_we, imem_addr, imem_wdata, cpu_rst, cpu_run, dmem_raddr,
           tx_start, tx_byte, load_count, overflow, dump_done
  );
endinterface
`default_nettype wire

// File: rtl/prog_load_controller.sv
`default_nettype none
// prog_load_controller: UART program loader, core release and data-memory dump sequencer.
// Optional trailing XOR checksum byte via DUMP_CHECKSUM_EN. Rev 1.0
module prog_load_controller #(
  parameter int IMEM_ADDR_W = 8,
  parameter int DMEM_ADDR_W = 8,
  parameter int DUMP_WORDS  = 16
) (
  input  logic                   CLOCK_50,
  input  logic                   rst,
  prog_load_controller_if.master bus
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    ARMED     = 3'd2,
    RUN       = 3'd3,
    DUMP_RD   = 3'd4,
    DUMP_SEND = 3'd5,
    DUMP_WAIT = 3'd6,
    DONE      = 3'd7
  } state_t;

  localparam logic [DMEM_ADDR_W-1:0] LAST_WORD = DMEM_ADDR_W'(DUMP_WORDS - 1);

  state_t      state;
  logic [1:0]  byte_idx;
  logic [23:0] asm_lo;
  logic        rd_wait;
  logic [31:0] dump_word;
  logic [1:0]  lane;
  logic        wait_first;
  logic [7:0]  lane_byte;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]  csum;
  logic        csum_phase;
`endif

  always_comb begin
    lane_byte = dump_word[7:0];
    case (lane)
      2'd1:    lane_byte = dump_word[15:8];
      2'd2:    lane_byte = dump_word[23:16];
      2'd3:    lane_byte = dump_word[31:24];
      default: lane_byte = dump_word[7:0];
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state          <= IDLE;
      byte_idx       <= 2'd0;
      asm_lo         <= 24'd0;
      rd_wait        <= 1'b0;
      dump_word      <= 32'd0;
      lane           <= 2'd0;
      wait_first     <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= 32'd0;
      bus.cpu_rst    <= 1'b1;
      bus.cpu_run    <= 1'b0;
      bus.dmem_raddr <= '0;
      bus.tx_start   <= 1'b0;
      bus.tx_byte    <= 8'd0;
      bus.load_count <= '0;
      bus.overflow   <= 1'b0;
      bus.dump_done  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum           <= 8'd0;
      csum_phase     <= 1'b0;
`endif
    end else begin
      bus.tx_start <= 1'b0;
      // Address/count advance after the write strobe so imem_addr is stable while imem_we is high.
      if (bus.imem_we) begin
        bus.imem_we    <= 1'b0;
        bus.imem_addr  <= bus.imem_addr + 1'b1;
        bus.load_count <= bus.load_count + 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.Enable_Instruction_Input) begin
            state          <= LOAD;
            bus.load_count <= '0;
            bus.imem_addr  <= '0;
            byte_idx       <= 2'd0;
            bus.overflow   <= 1'b0;
          end else if (bus.start) begin
            state       <= RUN;
            bus.cpu_rst <= 1'b0;
            bus.cpu_run <= 1'b1;
          end
        end

        LOAD: begin
          if (bus.rx_valid) begin
            case (byte_idx)
              2'd0: asm_lo[7:0]   <= bus.rx_byte;
              2'd1: asm_lo[15:8]  <= bus.rx_byte;
              2'd2: asm_lo[23:16] <= bus.rx_byte;
              default: begin
                // MSB of load_count set means every instruction word has been written.
                if (bus.load_count[IMEM_ADDR_W]) begin
                  bus.overflow <= 1'b1;
                end else begin
                  bus.imem_we    <= 1'b1;
                  bus.imem_wdata <= {bus.rx_byte, asm_lo};
                end
              end
            endcase
            byte_idx <= byte_idx + 2'd1;
          end
          if (!bus.Enable_Instruction_Input) state <= ARMED;
        end

        ARMED: begin
          if (bus.start) begin
            state       <= RUN;
            bus.cpu_rst <= 1'b0;
            bus.cpu_run <= 1'b1;
          end else if (bus.Enable_Instruction_Input) begin
            state          <= LOAD;
            bus.load_count <= '0;
            bus.imem_addr  <= '0;
            byte_idx       <= 2'd0;
            bus.overflow   <= 1'b0;
          end
        end

        RUN: begin
          if (bus.Enable_Data_Output) begin
            state          <= DUMP_RD;
            bus.cpu_run    <= 1'b0;
            bus.dmem_raddr <= '0;
            lane           <= 2'd0;
            rd_wait        <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum           <= 8'd0;
            csum_phase     <= 1'b0;
`endif
          end
        end

        DUMP_RD: begin
          rd_wait <= 1'b1;
          if (rd_wait) begin
            dump_word <= bus.dmem_rdata;
            state     <= DUMP_SEND;
          end
        end

        DUMP_SEND: begin
          if (!bus.tx_busy) begin
            bus.tx_start <= 1'b1;
            wait_first   <= 1'b1;
            state        <= DUMP_WAIT;
`ifdef DUMP_CHECKSUM_EN
            if (csum_phase) begin
              bus.tx_byte <= csum;
            end else begin
              bus.tx_byte <= lane_byte;
              csum        <= csum ^ lane_byte;
            end
`else
            bus.tx_byte <= lane_byte;
`endif
          end
        end

        DUMP_WAIT: begin
          // First cycle skipped: tx_busy may not have risen yet after tx_start.
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (!bus.tx_busy) begin
            if (lane != 2'd3) begin
              lane  <= lane + 2'd1;
              state <= DUMP_SEND;
            end else if (bus.dmem_raddr != LAST_WORD) begin
              bus.dmem_raddr <= bus.dmem_raddr + 1'b1;
              lane           <= 2'd0;
              rd_wait        <= 1'b0;
              state          <= DUMP_RD;
            end else begin
`ifdef DUMP_CHECKSUM_EN
              if (!csum_phase) begin
                csum_phase <= 1'b1;
                state      <= DUMP_SEND;
              end else begin
                state         <= DONE;
                bus.dump_done <= 1'b1;
              end
`else
              state         <= DONE;
              bus.dump_done <= 1'b1;
`endif
            end
          end
        end

        DONE: begin
          bus.dump_done <= 1'b1;
          bus.cpu_run   <= 1'b0;
          bus.cpu_rst   <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
